uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter with a small byte FIFO and per-frame
//            latched bit-period divisor.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                clkdiv,
    input  logic                       enable,
    input  logic [7:0]                 tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic                       ser_tx,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic [7:0]          r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic [1:0]  r_state;
    logic [15:0] r_div;
    logic [15:0] r_tick;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_ser;

    logic        w_push;
    logic        w_pop;
    logic        w_bit_end;
    logic        w_start_ok;
    logic [15:0] w_eff_div;

    assign tx_ready   = (r_count < c_depth);
    assign w_push     = tx_valid && tx_ready;
    assign w_bit_end  = (r_tick == (r_div - 16'd1));
    assign w_start_ok = enable && (r_count != '0);
    // A new frame starts from IDLE, or straight out of a finishing stop bit.
    assign w_pop      = w_start_ok &&
                        ((r_state == c_st_idle) || ((r_state == c_st_stop) && w_bit_end));
    assign w_eff_div  = (clkdiv < 16'd2) ? 16'd2 : clkdiv;

    assign ser_tx     = r_ser;
    assign busy       = (r_state != c_st_idle) || (r_count != '0);
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_div   <= 16'd2;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ser   <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_ser <= 1'b1;
                    if (w_pop) begin
                        r_state <= c_st_start;
                        r_shift <= r_mem[r_rd_ptr];
                        r_div   <= w_eff_div;
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_ser   <= 1'b0;
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_ser   <= r_shift[0];
                        r_state <= c_st_data;
                    end else begin
                        r_tick <= r_tick + 16'd1;
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        r_tick <= '0;
                        if (r_bit == 3'd7) begin
                            r_ser   <= 1'b1;
                            r_state <= c_st_stop;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_ser   <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_tick <= r_tick + 16'd1;
                    end
                end
                c_st_stop: begin
                    if (w_bit_end) begin
                        r_tick <= '0;
                        if (w_pop) begin
                            r_state <= c_st_start;
                            r_shift <= r_mem[r_rd_ptr];
                            r_div   <= w_eff_div;
                            r_bit   <= '0;
                            r_ser   <= 1'b0;
                        end else begin
                            r_state <= c_st_idle;
                            r_ser   <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 16'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_ser   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx; a line monitor checks every
//            cycle of every frame against a queue of expected bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] clkdiv;
    logic        enable;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ser_tx;
    logic        busy;
    logic [2:0]  fifo_count;

    uart_tx #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .clkdiv     (clkdiv),
        .enable     (enable),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         bitlen;
    } exp_t;

    typedef struct {
        logic [15:0] div;
        logic [7:0]  data;
        int          bitlen;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   vectors = 0;
    int   fails   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input int bitlen);
        tx_data  = d;
        tx_valid = 1'b1;
        sb.push_back('{d, bitlen});
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int k = 0; k < limit; k++) begin
            if (!busy) break;
            tick(1);
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_ser", {31'd0, ser_tx}, 32'd1);
    endtask

    // Frame monitor: every cycle of a frame is compared with the expected level.
    initial begin : monitor
        exp_t       e;
        logic [9:0] frame;
        bit         bad;
        bit         abort;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && ser_tx === 1'b0) begin
                vectors++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_frame: ser_tx low with nothing queued at %0t", $time);
                    for (int k = 0; k < 400 && ser_tx !== 1'b1; k++) begin
                        @(posedge clk);
                        #1;
                    end
                end else begin
                    e     = sb.pop_front();
                    frame = {1'b1, e.data, 1'b0};
                    bad   = 1'b0;
                    abort = 1'b0;
                    for (int b = 0; b < 10 && !abort; b++) begin
                        for (int c = 0; c < e.bitlen && !abort; c++) begin
                            if (b != 0 || c != 0) begin
                                @(posedge clk);
                                #1;
                            end
                            if (reset) begin
                                abort = 1'b1;
                            end else if (ser_tx !== frame[b] && !bad) begin
                                bad = 1'b1;
                                $display("FAIL frame_%02h: bit %0d cycle %0d got %b expected %b at %0t",
                                         e.data, b, c, ser_tx, frame[b], $time);
                            end
                        end
                    end
                    if (bad) fails++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vecs[0] = '{16'd4,  8'h55, 4};
        vecs[1] = '{16'd0,  8'hF0, 2};
        vecs[2] = '{16'd1,  8'h0F, 2};
        vecs[3] = '{16'd2,  8'h81, 2};
        vecs[4] = '{16'd7,  8'h3C, 7};
        vecs[5] = '{16'd13, 8'hA5, 13};

        // Reset with tx_valid asserted: the byte must be ignored.
        reset    = 1'b1;
        clkdiv   = 16'd4;
        enable   = 1'b1;
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        tick(3);
        check("rst_ser", {31'd0, ser_tx}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        tx_valid = 1'b0;
        reset    = 1'b0;
        tick(3);
        check("post_rst_ser", {31'd0, ser_tx}, 32'd1);
        check("post_rst_count", {29'd0, fifo_count}, 32'd0);

        // Single frames across divisors, including the 0/1 -> 2 clamp.
        for (int i = 0; i < 6; i++) begin
            clkdiv = vecs[i].div;
            push_byte(vecs[i].data, vecs[i].bitlen);
            check("vec_count_E", {29'd0, fifo_count}, 32'd1);
            check("vec_ser_E", {31'd0, ser_tx}, 32'd1);
            tick(1);
            check("vec_start_E1", {31'd0, ser_tx}, 32'd0);
            check("vec_count_E1", {29'd0, fifo_count}, 32'd0);
            tick(10 * vecs[i].bitlen - 1);
            check("vec_busy_last", {31'd0, busy}, 32'd1);
            tick(1);
            check("vec_busy_after", {31'd0, busy}, 32'd0);
            check("vec_ser_after", {31'd0, ser_tx}, 32'd1);
        end

        // Three back-to-back frames with no idle gap.
        clkdiv = 16'd5;
        push_byte(8'h41, 5);
        push_byte(8'h42, 5);
        push_byte(8'h0A, 5);
        check("b2b_count", {29'd0, fifo_count}, 32'd2);
        tick(148);
        check("b2b_busy_end", {31'd0, busy}, 32'd1);
        tick(1);
        check("b2b_busy_after", {31'd0, busy}, 32'd0);

        // Fill FIFO while disabled, hold a fifth byte, then enable.
        clkdiv = 16'd3;
        enable = 1'b0;
        push_byte(8'h10, 3);
        push_byte(8'h20, 3);
        push_byte(8'h30, 3);
        push_byte(8'h40, 3);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_ready", {31'd0, tx_ready}, 32'd0);
        check("full_ser", {31'd0, ser_tx}, 32'd1);
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        sb.push_back('{8'h99, 3});
        tick(2);
        check("full_hold_count", {29'd0, fifo_count}, 32'd4);
        enable = 1'b1;
        tick(1);
        check("full_pop_count", {29'd0, fifo_count}, 32'd3);
        check("full_pop_ser", {31'd0, ser_tx}, 32'd0);
        check("full_pop_ready", {31'd0, tx_ready}, 32'd1);
        tick(1);
        check("full_refill_count", {29'd0, fifo_count}, 32'd4);
        tx_valid = 1'b0;
        wait_idle(200);

        // Enable dropped mid-frame: current frame completes, next waits.
        clkdiv = 16'd2;
        push_byte(8'h5A, 2);
        push_byte(8'hA6, 2);
        enable = 1'b0;
        tick(20);
        check("en_off_ser", {31'd0, ser_tx}, 32'd1);
        check("en_off_busy", {31'd0, busy}, 32'd1);
        check("en_off_count", {29'd0, fifo_count}, 32'd1);
        tick(5);
        check("en_off_hold", {31'd0, ser_tx}, 32'd1);
        enable = 1'b1;
        tick(1);
        check("en_on_start", {31'd0, ser_tx}, 32'd0);
        wait_idle(100);

        // Asynchronous reset during data bit 3 of 0xA5 with two bytes queued.
        clkdiv = 16'd4;
        push_byte(8'hA5, 4);
        push_byte(8'h11, 4);
        push_byte(8'h22, 4);
        tick(16);
        check("rst_mid_bit3", {31'd0, ser_tx}, 32'd0);
        check("rst_mid_count", {29'd0, fifo_count}, 32'd2);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_ser", {31'd0, ser_tx}, 32'd1);
        check("rst_mid_cnt0", {29'd0, fifo_count}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        tick(2);
        sb.delete();
        reset = 1'b0;
        tick(40);
        check("rst_after_ser", {31'd0, ser_tx}, 32'd1);
        check("rst_after_busy", {31'd0, busy}, 32'd0);

        // Divisor change mid-frame applies only to the next frame.
        clkdiv = 16'd8;
        push_byte(8'h3C, 8);
        push_byte(8'hC3, 4);
        tick(19);
        clkdiv = 16'd4;
        tick(60);
        check("div_f1_stop", {31'd0, ser_tx}, 32'd1);
        check("div_f1_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("div_f2_start", {31'd0, ser_tx}, 32'd0);
        tick(39);
        check("div_f2_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("div_f2_done", {31'd0, busy}, 32'd0);

        tick(5);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
